// File: rtl/oled_text_arbiter.sv
// oled_text_arbiter: owns the 64-character text frame for the Pmod OLED driver,
// round-robin arbitrates single-character writes from two requesters, coalesces
// them into rate-limited update pulses and sequences driver power-on after reset.
// Optional feature macro: OLED_SKIP_REDUNDANT_EN -- writes and clears that leave
// the frame unchanged are acknowledged but do not dirty it or start the holdoff.
module oled_text_arbiter #(
    parameter int unsigned POWER_DELAY    = 100,
    parameter int unsigned UPDATE_HOLDOFF = 1000,
    parameter logic [7:0]  BLANK_CHAR     = 8'h20
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_a_valid,
    output logic         o_a_ready,
    input  logic [5:0]   i_a_addr,
    input  logic [7:0]   i_a_char,
    input  logic         i_b_valid,
    output logic         o_b_ready,
    input  logic [5:0]   i_b_addr,
    input  logic [7:0]   i_b_char,
    input  logic         i_clear,
    input  logic         i_flush,
    input  logic         i_oled_busy,
    output logic         o_power_on,
    output logic         o_update,
    output logic [511:0] o_display_data,
    output logic         o_dirty
);

    localparam int unsigned PwrW  = (POWER_DELAY > 1) ? $clog2(POWER_DELAY) : 1;
    localparam int unsigned HoldW = (UPDATE_HOLDOFF > 1) ? $clog2(UPDATE_HOLDOFF) : 1;

    typedef enum logic [2:0] {
        StPwrWait,
        StIdle,
        StHold,
        StUpd,
        StBusy
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [PwrW-1:0]  r_pwr_cnt;
    logic [HoldW-1:0] r_hold_cnt;
    logic [1:0]       r_busy_cnt;
    logic             r_power_on;
    logic             r_dirty;
    logic             r_rr_b;
    logic [7:0]       r_frame [64];

    logic             w_win;
    logic             w_a_gnt;
    logic             w_b_gnt;
    logic             w_wr_en;
    logic             w_clr_en;
    logic             w_mark;
    logic [5:0]       w_wr_addr;
    logic [7:0]       w_wr_char;

    // Write window and round-robin grant; a clear steals the cycle from both requesters
    always_comb begin
        w_win     = (r_state == StIdle) || (r_state == StHold);
        w_a_gnt   = w_win && !i_clear && i_a_valid && (!i_b_valid || !r_rr_b);
        w_b_gnt   = w_win && !i_clear && i_b_valid && (!i_a_valid || r_rr_b);
        w_wr_en   = w_a_gnt || w_b_gnt;
        w_wr_addr = w_a_gnt ? i_a_addr : i_b_addr;
        w_wr_char = w_a_gnt ? i_a_char : i_b_char;
        w_clr_en  = w_win && i_clear;
    end

`ifdef OLED_SKIP_REDUNDANT_EN
    logic w_wr_diff;
    logic w_clr_diff;

    // Only writes/clears that actually change a stored byte dirty the frame
    always_comb begin
        w_wr_diff  = (r_frame[w_wr_addr] != w_wr_char);
        w_clr_diff = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (r_frame[i] != BLANK_CHAR) begin
                w_clr_diff = 1'b1;
            end
        end
        w_mark = (w_wr_en && w_wr_diff) || (w_clr_en && w_clr_diff);
    end
`else
    // Every accepted write or clear dirties the frame
    assign w_mark = w_wr_en || w_clr_en;
`endif

    // Next-state: power-up wait, coalescing holdoff, update pulse, driver busy wait
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StPwrWait: begin
                if (r_pwr_cnt == PwrW'(POWER_DELAY - 1)) w_state_next = StIdle;
            end
            StIdle: begin
                if (i_flush)     w_state_next = StUpd;
                else if (w_mark) w_state_next = StHold;
            end
            StHold: begin
                if (i_flush || (r_hold_cnt == '0)) w_state_next = StUpd;
            end
            StUpd: begin
                w_state_next = StBusy;
            end
            StBusy: begin
                // oled_busy may lag the update pulse, so only trust it after two cycles
                if ((r_busy_cnt == 2'd2) && !i_oled_busy) w_state_next = StIdle;
            end
            default: begin
                w_state_next = StPwrWait;
            end
        endcase
    end

    // State register, counters, power_on, dirty flag and round-robin pointer
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= StPwrWait;
            r_pwr_cnt  <= '0;
            r_hold_cnt <= '0;
            r_busy_cnt <= '0;
            r_power_on <= 1'b0;
            r_dirty    <= 1'b0;
            r_rr_b     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StPwrWait) begin
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
                if (w_state_next == StIdle) r_power_on <= 1'b1;
            end
            // Holdoff loads only on entry so later writes cannot postpone the update
            if ((r_state == StIdle) && (w_state_next == StHold)) begin
                r_hold_cnt <= HoldW'(UPDATE_HOLDOFF - 1);
            end else if ((r_state == StHold) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - 1'b1;
            end
            if (r_state == StUpd) begin
                r_busy_cnt <= '0;
            end else if ((r_state == StBusy) && (r_busy_cnt != 2'd2)) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end
            if (r_state == StUpd) begin
                r_dirty <= 1'b0;
            end else if (w_mark) begin
                r_dirty <= 1'b1;
            end
            if (w_a_gnt) begin
                r_rr_b <= 1'b1;
            end else if (w_b_gnt) begin
                r_rr_b <= 1'b0;
            end
        end
    end

    // Frame buffer: blank fill on reset/clear, otherwise the granted character write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < 64; i++) begin
                r_frame[i] <= BLANK_CHAR;
            end
        end else if (w_clr_en) begin
            for (int i = 0; i < 64; i++) begin
                r_frame[i] <= BLANK_CHAR;
            end
        end else if (w_wr_en) begin
            r_frame[w_wr_addr] <= w_wr_char;
        end
    end

    // Position 0 sits in the most significant byte of the driver frame
    always_comb begin
        o_display_data = '0;
        for (int i = 0; i < 64; i++) begin
            o_display_data[511 - 8*i -: 8] = r_frame[i];
        end
    end

    assign o_a_ready  = w_a_gnt;
    assign o_b_ready  = w_b_gnt;
    assign o_power_on = r_power_on;
    assign o_update   = (r_state == StUpd);
    assign o_dirty    = r_dirty;

endmodule
